sha_digest_check: RTL and testbench
===================================

Name: sha_digest_check

Overview:
- Downstream stage of the pipelined SHA-256 round block.
- On that block's completion pulse it captures the final working variables a..h, the chaining value H and the nonce.
- It forms the 256-bit digest (H + state, per word, mod 2^32) and tests it against the difficulty target.
- It presents the result on a valid/ready output port to the nonce reporter or to the second-hash stage.

Parameters:
- ZERO_BITS, 32, required count of leading zero bits of byteswap(digest word 7); legal range 1..32.
- REPORT_ALL, 0, 1 = emit every digest (feeds second SHA pass); 0 = emit only digests that meet the target.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  1  one-cycle completion pulse from the round stage
- a, b, c, d, e, f, g, h  in  32 each  final working variables
- Hin  in  256  chaining value; word i at [255-32i -: 32], word 0 in MSBs
- nonce  in  32  nonce tied to this hash
- out_ready  in  1  consumer ready
- out_valid  out  1  result valid
- digest  out  256  H + state, same word order as Hin
- nonce_out  out  32  nonce of the presented digest
- found  out  1  digest meets the target (qualified by out_valid)
- busy  out  1  state != IDLE
- hash_cnt  out  32  digests computed; wraps
- drop_cnt  out  16  rejected en pulses; saturates at 0xFFFF

Behaviour:
- Reset state: every output is 0 and state is IDLE. Capture registers are cleared.
- Reset asserted mid-operation abandons the hash in flight; no result is emitted.
- FSM states: IDLE, ADD, CMP, HOLD.
- IDLE, en=1: register a..h, Hin and nonce; go to ADD.
- ADD: compute the 8 word sums in parallel, each 32-bit with carry discarded. Register digest; go to CMP.
- CMP: compute tail = byteswap(digest word 7). found_i = (tail[31 -: ZERO_BITS] == 0). Increment hash_cnt.
  - If found_i or REPORT_ALL: drive out_valid=1 and found=found_i; go to HOLD.
  - Otherwise: return to IDLE; out_valid stays 0.
- HOLD: out_valid, digest, nonce_out and found are stable until out_ready=1.
  - Handshake cycle (out_valid && out_ready): out_valid drops the next cycle.
  - Same cycle en=1: capture the new inputs and go to ADD (back-to-back acceptance).
  - Otherwise: go to IDLE.
- Latency: en at cycle N gives out_valid at cycle N+3.
- The stage accepts one hash at a time. The round stage cannot be stalled.
- en accepted only in IDLE, or in HOLD with out_ready=1. Any other en is dropped and drop_cnt increments (saturating).
- Dropped pulses do not disturb the hash in flight.
- digest, nonce_out and found keep their last values after a handshake. Consumers qualify them with out_valid.
- hash_cnt wraps from 0xFFFFFFFF to 0.
- Simultaneous reset and en: reset wins.

Decomposition:
- Shared package/header, next to the existing SHA defines: W_SIZE, H_SIZE, WORD_S, a byteswap32 macro, and the FSM state encodings.
- One sub-module is natural: sha_digest_add. It is the 8-lane 32-bit word adder from state + Hin to digest, combinational, instantiated once. The FSM, compare and counters stay in the top.

Test Plan:
- Reset release, then IV + SHA-256("abc") final state in, REPORT_ALL=1: out_valid at N+3 with digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, found=0, hash_cnt=1.
- ZERO_BITS=32, REPORT_ALL=0, state chosen so word 7 sums to 0x00000000: found=1, out_valid=1, nonce_out equals input nonce 0x12345678.
  - Same run, word 7 = 0x01000000: tail=0x00000001, no output; hash_cnt increments.
- HOLD with out_ready=0 for 10 cycles, second en during the hold: output stable, drop_cnt=1.
  - Then out_ready=1 together with en: handshake completes and the new hash is presented 3 cycles later.
- en pulses in ADD and in CMP: both dropped, drop_cnt=2, first result unaffected.
  - Force 65540 drops: drop_cnt=0xFFFF.
- reset asserted in CMP: next cycle out_valid=0, busy=0, counters 0, no result ever emitted.
- Word-add overflow: a=0xFFFFFFFF with H0=0x00000002 gives digest word 0 = 0x00000001.

Source files
------------

// File: rtl/sha_digest_check_pkg.sv
// sha_digest_check_pkg: shared sizes, byte swap helper and FSM encoding
package sha_digest_check_pkg;
  localparam int W_SIZE = 32;
  localparam int H_SIZE = 256;
  localparam int WORD_S = 8;
  typedef enum logic [1:0] {IDLE, ADD, CMP, HOLD} state_t;
  function automatic logic [W_SIZE-1:0] byteswap32(input logic [W_SIZE-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/sha_digest_add.sv
// sha_digest_add: per-word modulo-2^32 addition of the final state onto the chaining value
module sha_digest_add
  import sha_digest_check_pkg::*;
(
  input  logic [H_SIZE-1:0] st,
  input  logic [H_SIZE-1:0] hin,
  output logic [H_SIZE-1:0] sum
);
  for (genvar i = 0; i < WORD_S; i++) begin : g_w
    assign sum[H_SIZE-1-W_SIZE*i -: W_SIZE] = st[H_SIZE-1-W_SIZE*i -: W_SIZE] + hin[H_SIZE-1-W_SIZE*i -: W_SIZE];
  end
endmodule

// File: rtl/sha_digest_check.sv
// sha_digest_check: forms the SHA-256 digest from the final round state and tests it against the target
module sha_digest_check
  import sha_digest_check_pkg::*;
#(
  parameter int ZERO_BITS = 32,
  parameter int REPORT_ALL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [W_SIZE-1:0]   a,
  input  logic [W_SIZE-1:0]   b,
  input  logic [W_SIZE-1:0]   c,
  input  logic [W_SIZE-1:0]   d,
  input  logic [W_SIZE-1:0]   e,
  input  logic [W_SIZE-1:0]   f,
  input  logic [W_SIZE-1:0]   g,
  input  logic [W_SIZE-1:0]   h,
  input  logic [H_SIZE-1:0]   Hin,
  input  logic [W_SIZE-1:0]   nonce,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [H_SIZE-1:0]   digest,
  output logic [W_SIZE-1:0]   nonce_out,
  output logic                found,
  output logic                busy,
  output logic [W_SIZE-1:0]   hash_cnt,
  output logic [15:0]         drop_cnt
);
  state_t state, state_n;
  logic [H_SIZE-1:0] st_q, hin_q, sum, sum_q;
  logic [W_SIZE-1:0] nonce_q, tail;
  logic take, found_i, emit;
  sha_digest_add u_add (.st(st_q), .hin(hin_q), .sum(sum));
  assign tail = byteswap32(sum_q[W_SIZE-1:0]);
  assign found_i = tail[W_SIZE-1 -: ZERO_BITS] == '0;
  assign take = en && (state == IDLE || (state == HOLD && out_ready));
  assign emit = state == CMP && (found_i || REPORT_ALL != 0);
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  always_comb state_n = take ? ADD : state == ADD ? CMP : state == CMP ? (emit ? HOLD : IDLE) : (state == HOLD && !out_ready) ? HOLD : IDLE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      st_q      <= '0;
      hin_q     <= '0;
      nonce_q   <= '0;
      sum_q     <= '0;
      digest    <= '0;
      nonce_out <= '0;
      found     <= 1'b0;
      hash_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (take) begin
        st_q    <= {a, b, c, d, e, f, g, h};
        hin_q   <= Hin;
        nonce_q <= nonce;
      end
      if (state == ADD) sum_q <= sum;
      if (state == CMP) hash_cnt <= hash_cnt + 32'd1;
      if (emit) begin
        digest    <= sum_q;
        nonce_out <= nonce_q;
        found     <= found_i;
      end
      if (en && !take && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
endmodule

// File: tb/tb_sha_digest_check.sv
// tb_sha_digest_check: scoreboard bench driving a report-all and a target-only instance in parallel
module tb_sha_digest_check;
  typedef struct {
    logic [255:0] dg;
    logic [31:0]  nc;
    logic         fd;
    int           cyc;
  } exp_t;
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] D_ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] D_HIT = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafebabe,
                                    32'h0badf00d, 32'h13579bdf, 32'h2468ace0, 32'h00000000};
  localparam logic [255:0] D_MISS = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafebabe,
                                     32'h0badf00d, 32'h13579bdf, 32'h2468ace0, 32'h01000000};
  localparam logic [255:0] ST_OV = {32'hffffffff, 224'h0};
  localparam logic [255:0] H_OV = {32'h00000002, 32'h11111111, 32'h22222222, 32'h33333333,
                                   32'h44444444, 32'h55555555, 32'h66666666, 32'h00000000};
  localparam logic [255:0] D_OV = {32'h00000001, 32'h11111111, 32'h22222222, 32'h33333333,
                                   32'h44444444, 32'h55555555, 32'h66666666, 32'h00000000};
  logic clk = 0, reset = 1, en = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0, h = 0, nonce = 0;
  logic [255:0] Hin = 0;
  logic ov [2], fd [2], bz [2];
  logic [255:0] dg [2];
  logic [31:0] no [2], hc [2];
  logic [15:0] dc [2];
  exp_t q0[$], q1[$];
  int cyc = 0, n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  sha_digest_check #(.ZERO_BITS(8), .REPORT_ALL(1)) u0 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .Hin(Hin), .nonce(nonce), .out_ready(out_ready), .out_valid(ov[0]), .digest(dg[0]),
    .nonce_out(no[0]), .found(fd[0]), .busy(bz[0]), .hash_cnt(hc[0]), .drop_cnt(dc[0]));
  sha_digest_check #(.ZERO_BITS(32), .REPORT_ALL(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .Hin(Hin), .nonce(nonce), .out_ready(out_ready), .out_valid(ov[1]), .digest(dg[1]),
    .nonce_out(no[1]), .found(fd[1]), .busy(bz[1]), .hash_cnt(hc[1]), .drop_cnt(dc[1]));
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask
  function automatic logic [255:0] sub8(input logic [255:0] dd, input logic [255:0] hh);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = dd[255-32*i -: 32] - hh[255-32*i -: 32];
    return r;
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [255:0] st, input logic [255:0] hv, input logic [31:0] nc,
                      input logic [255:0] dexp, input bit push);
    exp_t x;
    {a, b, c, d, e, f, g, h} = st;
    Hin = hv;
    nonce = nc;
    en = 1;
    x.dg = dexp;
    x.nc = nc;
    x.cyc = cyc + 3;
    if (push) begin
      x.fd = dexp[7:0] == 8'h0;
      q0.push_back(x);
      x.fd = dexp[31:0] == 32'h0;
      if (x.fd) q1.push_back(x);
    end
    tick();
    en = 0;
  endtask
  task automatic counters(input logic [31:0] hx, input logic [15:0] dx);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d hash_cnt", i), hc[i], hx);
      chk($sformatf("u%0d drop_cnt", i), dc[i], dx);
    end
  endtask
  logic pv [2] = '{0, 0};
  logic phs [2] = '{0, 0};
  exp_t cur [2];
  always @(negedge clk) begin
    exp_t x;
    bit have;
    for (int i = 0; i < 2; i++) begin
      if (ov[i] && phs[i]) chk($sformatf("u%0d valid after handshake", i), ov[i], 0);
      else if (ov[i] && !pv[i]) begin
        have = 0;
        if (i == 0 && q0.size() != 0) begin
          x = q0.pop_front();
          have = 1;
        end else if (i == 1 && q1.size() != 0) begin
          x = q1.pop_front();
          have = 1;
        end
        if (!have) chk($sformatf("u%0d spurious out_valid", i), ov[i], 0);
        else begin
          cur[i] = x;
          chk($sformatf("u%0d latency", i), cyc, x.cyc);
          chk($sformatf("u%0d digest", i), dg[i], x.dg);
          chk($sformatf("u%0d nonce_out", i), no[i], x.nc);
          chk($sformatf("u%0d found", i), fd[i], x.fd);
        end
      end else if (ov[i]) begin
        chk($sformatf("u%0d hold digest", i), dg[i], cur[i].dg);
        chk($sformatf("u%0d hold nonce", i), no[i], cur[i].nc);
        chk($sformatf("u%0d hold found", i), fd[i], cur[i].fd);
      end
      pv[i] = ov[i];
      phs[i] = ov[i] && out_ready;
    end
  end
  initial begin
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset out_valid", i), ov[i], 0);
      chk($sformatf("u%0d reset digest", i), dg[i], 0);
      chk($sformatf("u%0d reset nonce_out", i), no[i], 0);
      chk($sformatf("u%0d reset found", i), fd[i], 0);
      chk($sformatf("u%0d reset busy", i), bz[i], 0);
    end
    counters(0, 0);
    reset = 0;
    tick();
    send(sub8(D_ABC, IV), IV, 32'h00000001, D_ABC, 1);
    tick(6);
    counters(1, 0);
    send(sub8(D_HIT, IV), IV, 32'h12345678, D_HIT, 1);
    tick(6);
    send(sub8(D_MISS, IV), IV, 32'h00000009, D_MISS, 1);
    tick(6);
    counters(3, 0);
    send(ST_OV, H_OV, 32'h0000000a, D_OV, 1);
    tick(6);
    counters(4, 0);
    out_ready = 0;
    send(sub8(D_HIT, IV), IV, 32'h000000a1, D_HIT, 1);
    tick(5);
    {a, b, c, d, e, f, g, h} = {8{32'hdeadbeef}};
    Hin = ~IV;
    nonce = 32'hbad0bad0;
    en = 1;
    tick();
    en = 0;
    tick(5);
    counters(5, 1);
    out_ready = 1;
    send(ST_OV, H_OV, 32'h000000b2, D_OV, 1);
    tick(6);
    counters(6, 1);
    reset = 1;
    tick(2);
    reset = 0;
    counters(0, 0);
    send(sub8(D_HIT, IV), IV, 32'h000000c3, D_HIT, 1);
    Hin = 0;
    en = 1;
    tick(2);
    en = 0;
    tick(4);
    counters(1, 2);
    out_ready = 0;
    send(sub8(D_HIT, IV), IV, 32'h000000d4, D_HIT, 1);
    tick(3);
    en = 1;
    tick(65540);
    en = 0;
    counters(2, 16'hffff);
    out_ready = 1;
    tick(3);
    send(sub8(D_HIT, IV), IV, 32'h000000e5, D_HIT, 0);
    tick();
    reset = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d out_valid after reset in CMP", i), ov[i], 0);
      chk($sformatf("u%0d busy after reset in CMP", i), bz[i], 0);
    end
    counters(0, 0);
    en = 1;
    tick();
    reset = 0;
    en = 0;
    for (int i = 0; i < 2; i++) chk($sformatf("u%0d busy after reset with en", i), bz[i], 0);
    tick(6);
    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
